dmem_readback: RTL

DMEM_READBACK -- requirements
Module: dmem_readback

---
 rtl/dmem_readback_pkg.sv | 18 +
 rtl/dmem_readback_if.sv | 36 +++
 rtl/rb_fifo2.sv | 64 ++++++
 rtl/dmem_readback.sv | 133 +++++++++++++
 4 files changed

// File: rtl/dmem_readback_pkg.sv
// Shared definitions for the data-memory readback engine: FSM encoding,
// word stride and readback FIFO depth.
package dmem_readback_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } rb_state_t;

    // Byte distance between consecutive data-memory words.
    localparam int unsigned WORD_STRIDE = 4;

    // Readback FIFO depth; also the cap on FIFO occupancy plus reads in flight.
    localparam int unsigned FIFO_DEPTH = 2;

endpackage

// File: rtl/dmem_readback_if.sv
// Bus bundle of the readback engine.
//   start_in/base_addr/word_count : run request (sampled in IDLE)
//   mem_rd_en/mem_addr/mem_rdata  : data-memory read port; mem_rdata is
//                                   captured on the rising edge that closes
//                                   the mem_rd_en cycle
//   out_valid/out_ready/out_addr/out_data : word stream to the consumer
//   busy/done                     : run status
// master = readback engine, slave = core / memory / consumer side.
interface dmem_readback_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
);
    logic              start_in;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_count;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_addr;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;

    modport master (
        input  start_in, base_addr, word_count, mem_rdata, out_ready,
        output mem_rd_en, mem_addr, out_valid, out_addr, out_data, busy, done
    );

    modport slave (
        output start_in, base_addr, word_count, mem_rdata, out_ready,
        input  mem_rd_en, mem_addr, out_valid, out_addr, out_data, busy, done
    );
endinterface

// File: rtl/rb_fifo2.sv
// Two-entry FIFO built as head/tail registers so the head drives the output
// directly from a flop.
//   clk, rst        : clock, asynchronous active-high reset
//   i_push, i_data  : write strobe and payload (never pushed when full)
//   i_pop           : consume head (ignored when empty)
//   o_valid, o_data : FIFO non-empty and head payload
//   o_count         : current occupancy (0..2)
module rb_fifo2 #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_count;
    logic             r_valid;
    logic             w_pop;
    logic [1:0]       w_count_nxt;

    assign w_pop       = i_pop & r_valid;
    assign w_count_nxt = r_count + 2'(i_push) - 2'(w_pop);

    // Head always holds the oldest entry; a pop shifts the tail forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != 2'd0);
            case ({i_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_head <= i_data;
                    else                 r_tail <= i_data;
                end
                2'b01: r_head <= r_tail;
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_head;
    assign o_count = r_count;

endmodule

// File: rtl/dmem_readback.sv
// Data-memory readback engine: on start, reads word_count consecutive words
// from base_addr (4-byte stride, wrapping) and streams {address, data} to a
// valid/ready consumer through a 2-entry FIFO.
//   clk   : clock
//   reset : asynchronous active-high reset
//   bus   : dmem_readback_if.master (request, memory port, output stream,
//           busy/done status)
module dmem_readback
    import dmem_readback_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    dmem_readback_if.master        bus
);

    localparam int unsigned PAY_W = ADDR_W + DATA_W;

    rb_state_t         r_state;
    rb_state_t         w_state_nxt;
    logic              r_rd_en;
    logic              w_rd_en_nxt;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic [ADDR_W-1:0] r_next_addr;
    logic [ADDR_W-1:0] w_next_addr_nxt;
    logic [CNT_W-1:0]  r_remaining;
    logic [CNT_W-1:0]  w_remaining_nxt;
    logic              r_busy;
    logic              r_done;

    logic              w_fifo_valid;
    logic [PAY_W-1:0]  w_fifo_data;
    logic [1:0]        w_fifo_count;
    logic              w_pop;
    logic [2:0]        w_occ_after;
    logic              w_room;

    // The read issued last cycle lands in the FIFO at this edge, so it counts
    // against the space available to a read issued now.
    assign w_pop       = w_fifo_valid & bus.out_ready;
    assign w_occ_after = 3'(w_fifo_count) + 3'(r_rd_en) - 3'(w_pop);
    assign w_room      = (w_occ_after < 3'(FIFO_DEPTH));

    rb_fifo2 #(
        .WIDTH (PAY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (r_rd_en),
        .i_data  ({r_mem_addr, bus.mem_rdata}),
        .i_pop   (w_pop),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_data),
        .o_count (w_fifo_count)
    );

    // Next-state and read-issue decision.
    always_comb begin
        w_state_nxt     = r_state;
        w_rd_en_nxt     = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_next_addr_nxt = r_next_addr;
        w_remaining_nxt = r_remaining;
        case (r_state)
            ST_IDLE: begin
                if (bus.start_in) begin
                    if (bus.word_count != '0) begin
                        w_state_nxt     = ST_READ;
                        w_rd_en_nxt     = 1'b1;
                        w_mem_addr_nxt  = bus.base_addr;
                        w_next_addr_nxt = bus.base_addr + ADDR_W'(WORD_STRIDE);
                        w_remaining_nxt = bus.word_count - CNT_W'(1);
                    end else begin
                        w_state_nxt = ST_FIN;
                    end
                end
            end
            ST_READ: begin
                if (r_remaining == '0) begin
                    w_state_nxt = ST_DRAIN;
                end else if (w_room) begin
                    w_rd_en_nxt     = 1'b1;
                    w_mem_addr_nxt  = r_next_addr;
                    w_next_addr_nxt = r_next_addr + ADDR_W'(WORD_STRIDE);
                    w_remaining_nxt = r_remaining - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                if (w_occ_after == 3'd0) w_state_nxt = ST_FIN;
            end
            ST_FIN: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_rd_en     <= 1'b0;
            r_mem_addr  <= '0;
            r_next_addr <= '0;
            r_remaining <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_en     <= w_rd_en_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_next_addr <= w_next_addr_nxt;
            r_remaining <= w_remaining_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= (w_state_nxt == ST_FIN);
        end
    end

    assign bus.mem_rd_en = r_rd_en;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.out_valid = w_fifo_valid;
    assign bus.out_addr  = w_fifo_data[PAY_W-1 -: ADDR_W];
    assign bus.out_data  = w_fifo_data[DATA_W-1:0];
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
